// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 row driver: FSM states, pixel word layout and helpers.
package hub75_pkg;

  localparam int unsigned PIX_W = 6;

  // Pixel word as presented on s_axi_data: {r1,g1,b1,r0,g0,b0}
  typedef struct packed {
    logic r1;
    logic g1;
    logic b1;
    logic r0;
    logic g0;
    logic b0;
  } pixel_t;

  typedef enum logic [2:0] {
    LOAD,
    SETUP,
    CLK_HIGH,
    BLANK,
    LATCH,
    DISPLAY
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hub75_phase_timer.sv
// Loadable down-counter shared by all timed FSM phases; done while the count sits at zero.
module hub75_phase_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c_o = (cnt_q == '0);

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 panel row driver: shifts COLUMNS pixel words per row, then blanks, latches and
// displays the row before moving on to the next row pair.
module hub75_row_driver
  import hub75_pkg::*;
#(
  parameter int unsigned COLUMNS    = 64,
  parameter int unsigned ROW_PAIRS  = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned LAT_CYCLES = 2,
  parameter int unsigned OE_CYCLES  = 256
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              s_axi_valid,
  input  logic [PIX_W-1:0]  s_axi_data,
  output logic              s_axi_ready,
  output logic              hub_r0,
  output logic              hub_g0,
  output logic              hub_b0,
  output logic              hub_r1,
  output logic              hub_g1,
  output logic              hub_b1,
  output logic              hub_clk,
  output logic              hub_lat,
  output logic              hub_oe_n,
  output logic [ADDR_W-1:0] hub_addr,
  output logic              o_frame_done
);

  localparam int unsigned COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int unsigned PH_MAX = max3(CLK_DIV, LAT_CYCLES, OE_CYCLES);
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  pixel_t            pix_q, pix_d;
  logic              ready_q, ready_d;
  logic              hclk_q, hclk_d;
  logic              lat_q, lat_d;
  logic              oe_n_q, oe_n_d;
  logic              fdone_q, fdone_d;

  logic              tmr_load_c;
  logic [PH_W-1:0]   tmr_val_c;
  logic              tmr_done_c;

  hub75_phase_timer #(
    .CNT_W(PH_W)
  ) u_timer (
    .clk       (clk),
    .areset    (areset),
    .load_i    (tmr_load_c),
    .load_val_i(tmr_val_c),
    .done_c_o  (tmr_done_c)
  );

  // Next-state and next-output logic; outputs are decoded from the next state so they
  // line up with the state they describe once registered.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pix_d      = pix_q;
    addr_d     = addr_q;
    fdone_d    = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;

    case (state_q)
      LOAD: begin
        if (s_axi_valid && ready_q) begin
          pix_d      = pixel_t'(s_axi_data);
          state_d    = SETUP;
          tmr_load_c = 1'b1;
          tmr_val_c  = PH_W'(CLK_DIV - 1);
        end
      end
      SETUP: begin
        if (tmr_done_c) begin
          state_d    = CLK_HIGH;
          tmr_load_c = 1'b1;
          tmr_val_c  = PH_W'(CLK_DIV - 1);
        end
      end
      CLK_HIGH: begin
        if (tmr_done_c) begin
          if (col_q == COL_W'(COLUMNS - 1)) begin
            col_d   = '0;
            state_d = BLANK;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = LOAD;
          end
        end
      end
      BLANK: begin
        state_d    = LATCH;
        tmr_load_c = 1'b1;
        tmr_val_c  = PH_W'(LAT_CYCLES - 1);
      end
      LATCH: begin
        if (tmr_done_c) begin
          state_d    = DISPLAY;
          tmr_load_c = 1'b1;
          tmr_val_c  = PH_W'(OE_CYCLES - 1);
        end
      end
      DISPLAY: begin
        if (tmr_done_c) begin
          state_d = LOAD;
          if (row_q == ADDR_W'(ROW_PAIRS - 1)) begin
            row_d   = '0;
            fdone_d = 1'b1;
          end else begin
            row_d = row_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Address changes on entry to BLANK so it is already settled while the panel is dark.
    if (state_d == BLANK) begin
      addr_d = row_q;
    end

    ready_d = (state_d == LOAD);
    hclk_d  = (state_d == CLK_HIGH);
    lat_d   = (state_d == LATCH);
    oe_n_d  = (state_d != DISPLAY);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= LOAD;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      ready_q <= 1'b0;
      hclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      ready_q <= ready_d;
      hclk_q  <= hclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      fdone_q <= fdone_d;
    end
  end

  assign s_axi_ready  = ready_q;
  assign hub_r1       = pix_q.r1;
  assign hub_g1       = pix_q.g1;
  assign hub_b1       = pix_q.b1;
  assign hub_r0       = pix_q.r0;
  assign hub_g0       = pix_q.g0;
  assign hub_b0       = pix_q.b0;
  assign hub_clk      = hclk_q;
  assign hub_lat      = lat_q;
  assign hub_oe_n     = oe_n_q;
  assign hub_addr     = addr_q;
  assign o_frame_done = fdone_q;

endmodule

// File: tb/tb_hub75_row_driver.sv
// Scoreboard bench for hub75_row_driver: stimulus queues expected pixels and row events,
// a negedge monitor pops and compares them as the panel signals appear.
module tb_hub75_row_driver;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 2;
  localparam int unsigned AW   = 1;
  localparam int unsigned CDIV = 1;
  localparam int unsigned LATC = 2;
  localparam int unsigned OEC  = 3;

  logic          clk = 1'b0;
  logic          areset;
  logic          s_axi_valid;
  logic [5:0]    s_axi_data;
  logic          s_axi_ready;
  logic          hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
  logic          hub_clk, hub_lat, hub_oe_n;
  logic [AW-1:0] hub_addr;
  logic          o_frame_done;
  logic [5:0]    colour;

  hub75_row_driver #(
    .COLUMNS   (COLS),
    .ROW_PAIRS (ROWS),
    .ADDR_W    (AW),
    .CLK_DIV   (CDIV),
    .LAT_CYCLES(LATC),
    .OE_CYCLES (OEC)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .s_axi_valid (s_axi_valid),
    .s_axi_data  (s_axi_data),
    .s_axi_ready (s_axi_ready),
    .hub_r0      (hub_r0),
    .hub_g0      (hub_g0),
    .hub_b0      (hub_b0),
    .hub_r1      (hub_r1),
    .hub_g1      (hub_g1),
    .hub_b1      (hub_b1),
    .hub_clk     (hub_clk),
    .hub_lat     (hub_lat),
    .hub_oe_n    (hub_oe_n),
    .hub_addr    (hub_addr),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  assign colour = {hub_r1, hub_g1, hub_b1, hub_r0, hub_g0, hub_b0};

  typedef struct {
    int addr;
    int lat;
    bit fd;
  } row_exp_t;

  logic [5:0] pix_q[$];
  row_exp_t   row_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic       prev_clk = 1'b0, prev_lat = 1'b0, prev_oe_n = 1'b1;
  logic [AW-1:0] prev_addr = '0, lat_addr = '0;
  logic [5:0] cur_px = '0;
  int         edges = 0, lat_len = 0, oe_len = 0, hs_cyc = 0, fd_count = 0;
  bit         hs_seen = 1'b0, fd_exp = 1'b0;

  always @(negedge clk) begin
    if (areset) begin
      prev_clk  = 1'b0;
      prev_lat  = 1'b0;
      prev_oe_n = 1'b1;
      prev_addr = '0;
      edges     = 0;
      lat_len   = 0;
      oe_len    = 0;
      hs_seen   = 1'b0;
    end else begin
      if (s_axi_ready && s_axi_valid && !hs_seen) begin
        hs_seen = 1'b1;
        hs_cyc  = cyc;
      end
      if (s_axi_ready) chk("oe_in_load", 32'(hub_oe_n), 32'd1);
      if (hub_clk && !prev_clk) begin
        edges++;
        chk("oe_during_shift", 32'(hub_oe_n), 32'd1);
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_edge: got colour %0h with no pixel queued", colour);
        end else begin
          cur_px = pix_q.pop_front();
          chk("pixel_at_edge", 32'(colour), 32'(cur_px));
        end
      end
      if (!hub_clk && prev_clk) chk("pixel_hold", 32'(colour), 32'(cur_px));
      if (hub_lat && !prev_lat) begin
        lat_len  = 1;
        lat_addr = hub_addr;
        if (row_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_latch: got addr %0d with no row queued", hub_addr);
        end else begin
          row_exp_t r;
          r = row_q.pop_front();
          chk("addr_latch", 32'(hub_addr), 32'(r.addr));
          chk("addr_blank", 32'(prev_addr), 32'(r.addr));
          chk("edges_per_row", 32'(edges), 32'(COLS));
          chk("hs_to_latch", hs_seen ? 32'(cyc - hs_cyc) : 32'hFFFF_FFFF, 32'(r.lat));
          fd_exp = r.fd;
        end
        edges   = 0;
        hs_seen = 1'b0;
      end else if (hub_lat) begin
        lat_len++;
      end
      if (!hub_lat && prev_lat) begin
        chk("lat_len", 32'(lat_len), 32'(LATC));
        chk("addr_stable", 32'(hub_addr), 32'(lat_addr));
      end
      if (!hub_oe_n && prev_oe_n) oe_len = 1;
      else if (!hub_oe_n) oe_len++;
      if (hub_oe_n && !prev_oe_n) begin
        chk("oe_len", 32'(oe_len), 32'(OEC));
        chk("frame_done", 32'(o_frame_done), 32'(fd_exp));
      end
      if (o_frame_done) fd_count++;
      prev_clk  = hub_clk;
      prev_lat  = hub_lat;
      prev_oe_n = hub_oe_n;
      prev_addr = hub_addr;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(s_axi_ready), 32'd0);
    chk({tag, "_hub_clk"}, 32'(hub_clk), 32'd0);
    chk({tag, "_lat"}, 32'(hub_lat), 32'd0);
    chk({tag, "_oe_n"}, 32'(hub_oe_n), 32'd1);
    chk({tag, "_addr"}, 32'(hub_addr), 32'd0);
    chk({tag, "_colour"}, 32'(colour), 32'd0);
    chk({tag, "_frame_done"}, 32'(o_frame_done), 32'd0);
  endtask

  task automatic send_px(input logic [5:0] d);
    bit ok = 1'b0;
    s_axi_valid = 1'b1;
    s_axi_data  = d;
    pix_q.push_back(d);
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_axi_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    chk("handshake", 32'(ok), 32'd1);
  endtask

  // Hold valid low for five LOAD cycles and confirm the shifter just waits.
  task automatic do_stall();
    bit seen = 1'b0;
    s_axi_valid = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = s_axi_ready;
    end
    chk("stall_reach_load", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_ready", 32'(s_axi_ready), 32'd1);
      chk("stall_hub_clk", 32'(hub_clk), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [23:0] pxs, input int addr, input int lat,
                          input bit fd, input bit stall);
    row_exp_t r;
    r.addr = addr;
    r.lat  = lat;
    r.fd   = fd;
    row_q.push_back(r);
    for (int c = 0; c < 4; c++) begin
      send_px(pxs[23-6*c -: 6]);
      if (stall && c == 1) do_stall();
    end
  endtask

  initial begin
    areset      = 1'b1;
    s_axi_valid = 1'b0;
    s_axi_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    areset = 1'b0;
    @(negedge clk);
    chk("ready_held_after_release", 32'(s_axi_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_first_assert", 32'(s_axi_ready), 32'd1);

    // Row 0 and row 1 of a frame, continuous valid
    send_row({6'h01, 6'h02, 6'h04, 6'h08}, 0, 13, 1'b0, 1'b0);
    send_row({6'h10, 6'h20, 6'h3F, 6'h15}, 1, 13, 1'b1, 1'b0);
    // Frame wrapped: address back to 0, with a valid stall after column 1
    send_row({6'h2A, 6'h07, 6'h38, 6'h00}, 0, 18, 1'b0, 1'b1);

    // Row 1 abandoned by reset during column 2
    send_px(6'h11);
    send_px(6'h22);
    send_px(6'h33);
    areset      = 1'b1;
    s_axi_valid = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    pix_q.delete();
    row_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    chk("ready_low_after_midrow_reset", 32'(s_axi_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_back_after_midrow_reset", 32'(s_axi_ready), 32'd1);

    send_row({6'h05, 6'h0A, 6'h30, 6'h0C}, 0, 13, 1'b0, 1'b0);
    send_row({6'h3F, 6'h00, 6'h21, 6'h12}, 1, 13, 1'b1, 1'b0);
    s_axi_valid = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    chk("frame_done_pulses", 32'(fd_count), 32'd2);
    chk("rows_left", 32'(row_q.size()), 32'd0);
    chk("pixels_left", 32'(pix_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
